// File: rtl/cpu_pkg.sv
// Shared CPU types: address/instruction widths, their typedefs and the fetch state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INST_W = 9;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Sequential PC advance; wraps naturally at 2^ADDR_W.
    function automatic addr_t next_pc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the combinational ROM and hands a
// registered instruction stream to decode over a valid/ready handshake.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter addr_t       RESET_PC = '0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    output logic [ADDR_W-1:0] Address,
    input  logic [INST_W-1:0] Instruction,
    output logic [INST_W-1:0] InstOut,
    output logic              InstValid,
    input  logic              InstReady,
    output logic [ADDR_W-1:0] InstPC,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Halt,
    output logic              Done,
    output logic [CNT_W-1:0]  InstCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fetch_state_t state;
    addr_t        pc;
    logic         xfer;

    assign Address = pc;
    assign xfer    = InstValid && InstReady;

    // Fetch FSM with PC, output register and retired-instruction counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            InstOut   <= '0;
            InstPC    <= '0;
            InstValid <= 1'b0;
            Done      <= 1'b0;
            InstCount <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        pc        <= StartAddr;
                        InstCount <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (Halt) begin
                        // The instruction handed over in the halt cycle still retires.
                        if (xfer && InstCount != CNT_MAX) begin
                            InstCount <= InstCount + CNT_W'(1);
                        end
                        InstValid <= 1'b0;
                        Done      <= 1'b1;
                        state     <= HALTED;
                    end else if (BranchTaken) begin
                        pc        <= BranchTarget;
                        InstValid <= 1'b0;
                    end else if (!InstValid || InstReady) begin
                        if (xfer && InstCount != CNT_MAX) begin
                            InstCount <= InstCount + CNT_W'(1);
                        end
                        InstOut   <= Instruction;
                        InstPC    <= pc;
                        InstValid <= 1'b1;
                        pc        <= next_pc(pc);
                    end
                end
                HALTED: begin
                    if (Start) begin
                        pc        <= StartAddr;
                        Done      <= 1'b0;
                        InstCount <= '0;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
